// File: rtl/axis_multi_sink.sv
// axis_multi_sink: NCH-channel AXI-Stream terminator with programmable backpressure,
// per-channel beat/packet/byte counters and tkeep legality checking.
module axis_multi_sink #(
    parameter int          DW     = 128,
    parameter int          NCH    = 3,
    parameter int          CW     = 32,
    parameter int          PERIOD = 4,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  clear,
    input  logic [NCH*DW-1:0]     axis_rx_tdata,
    input  logic [NCH*DW/8-1:0]   axis_rx_tkeep,
    input  logic [NCH-1:0]        axis_rx_tlast,
    input  logic [NCH-1:0]        axis_rx_tvalid,
    output logic [NCH-1:0]        axis_rx_tready,
    output logic [NCH*CW-1:0]     beat_count,
    output logic [NCH*CW-1:0]     pkt_count,
    output logic [NCH*CW-1:0]     byte_count,
    output logic [NCH*CW-1:0]     err_count,
    output logic [NCH-1:0]        err_flag
);
    localparam int KB = DW / 8;
    localparam int KW = $clog2(KB) + 1;
    localparam int PW = PERIOD > 1 ? $clog2(PERIOD) : 1;

    logic [PW-1:0] pcnt;

    function automatic logic [KW-1:0] popcnt(input logic [KB-1:0] k);
        popcnt = '0;
        for (int b = 0; b < KB; b++) popcnt += KW'(k[b]);
    endfunction

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? '1 : s[CW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) pcnt <= '0;
        else pcnt <= (pcnt == PW'(PERIOD - 1)) ? '0 : pcnt + PW'(1);
    end

    genvar i;
    for (i = 0; i < NCH; i++) begin : g_ch
        logic [15:0]   lfsr;
        logic          rdy, flag, acc, last, bad;
        logic [KB-1:0] keep, keep_inc;
        logic [CW-1:0] beat_q, pkt_q, byte_q, err_q;

        always_comb begin
            keep     = axis_rx_tkeep[i*KB +: KB];
            keep_inc = keep + KB'(1);
            last     = axis_rx_tlast[i];
            acc      = axis_rx_tvalid[i] & rdy;
            // a last beat must be a non-empty run of ones starting at byte 0
            bad      = last ? (keep == '0 || (keep & keep_inc) != '0) : (keep != '1);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                lfsr   <= SEED ^ 16'(i);
                rdy    <= 1'b0;
                flag   <= 1'b0;
                beat_q <= '0;
                pkt_q  <= '0;
                byte_q <= '0;
                err_q  <= '0;
            end else begin
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                rdy  <= mode == 2'd0 ? 1'b1 : mode == 2'd1 ? 1'b0 :
                        mode == 2'd2 ? (lfsr[1] | lfsr[0]) : (pcnt == '0);
                if (clear) begin
                    flag   <= 1'b0;
                    beat_q <= '0;
                    pkt_q  <= '0;
                    byte_q <= '0;
                    err_q  <= '0;
                end else if (acc) begin
                    flag   <= flag | bad;
                    beat_q <= sat_add(beat_q, CW'(1));
                    pkt_q  <= sat_add(pkt_q, CW'(last));
                    byte_q <= sat_add(byte_q, CW'(popcnt(keep)));
                    err_q  <= sat_add(err_q, CW'(bad));
                end
            end
        end

        assign axis_rx_tready[i]       = rdy;
        assign err_flag[i]             = flag;
        assign beat_count[i*CW +: CW]  = beat_q;
        assign pkt_count[i*CW +: CW]   = pkt_q;
        assign byte_count[i*CW +: CW]  = byte_q;
        assign err_count[i*CW +: CW]   = err_q;
    end

    logic unused_tdata;
    assign unused_tdata = ^axis_rx_tdata;
endmodule
